stream_mux: RTL and testbench
=============================

// Module: stream_mux
// PURPOSE
//  - N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes on every input and on the output.
//  - Two selection modes: fixed select (external sel) and round-robin arbitration across requesting channels.
//  - Sits between several producer streams and a single consumer. Successor to the 2:1 8-bit combinational mux.
// PARAMETERS
//  WIDTH  8  data width per channel, >=1
//  N_CH   4  number of input channels, >=2 (need not be a power of 2)
//  SELW   $clog2(N_CH)  localparam, width of sel/out_ch; not overridable
// PORTS
//  clk        in   1            rising-edge clock, single clock domain
//  rst        in   1            synchronous reset, active-high
//  in_data    in   N_CH*WIDTH   channel i at bits [i*WIDTH +: WIDTH]
//  in_valid   in   N_CH         channel i has data
//  in_ready   out  N_CH         channel i accepted this cycle when in_valid[i]&in_ready[i]
//  mode       in   1            0 = fixed select, 1 = round-robin
//  sel        in   SELW         channel chosen in fixed mode
//  out_data   out  WIDTH        registered output data
//  out_valid  out  1            output register holds a beat
//  out_ready  in   1            consumer accepts beat when out_valid&out_ready
//  out_ch     out  SELW         source channel of the current out_data
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is all-zero while rst=1.
//  - Single-entry output register. can_load = !out_valid | out_ready (drain and refill in the same cycle allowed).
//  - in_ready is combinational from can_load, mode, sel, in_valid and rr_ptr. At most one bit set per cycle.
//    in_ready never depends on in_valid of the same channel in fixed mode.
//  - Fixed mode: in_ready[sel]=can_load; all other bits 0.
//    sel>=N_CH: all in_ready=0 and nothing loads.
//  - Round-robin mode: grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo N_CH.
//    in_ready[grant]=can_load. If no in_valid is set, nothing is granted.
//  - Load (in_valid[g]&in_ready[g]) at edge: out_data<=in_data[g], out_ch<=g, out_valid<=1.
//    In RR mode, rr_ptr<=(g+1) mod N_CH (N_CH-1 wraps to 0).
//  - Unload without load: out_valid<=0. out_data/out_ch hold their last value.
//  - While out_valid=1 & out_ready=0: out_data and out_ch are stable; all in_ready=0.
//  - Latency: accepted beat appears on out_* exactly 1 cycle later.
//    Full throughput is 1 beat/cycle when out_ready=1 continuously.
//  - rr_ptr updates only on an RR-mode load. It holds across fixed-mode operation and mode changes.
//  - mode/sel are sampled combinationally each cycle. A change affects the next accept only, never the held beat.
//  - rst asserted mid-stream: held beat discarded, out_valid=0 next cycle, no in_ready during rst.
// TESTING
//  1 Reset: hold rst 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0.
//  2 Fixed: mode=0, sel=1, in_valid=4'b1111, ch1=8'h03, ch0=8'h01, out_ready=1
//    -> next cycle out_data=8'h03, out_ch=1. Then sel=0 -> out_data=8'h01.
//  3 Round-robin: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
//    Then in_valid=4'b0101 -> out_ch 0,2,0,2.
//  4 Backpressure: out_ready=0 after first beat -> out_valid stays 1, out_data stable, in_ready=0.
//    Release -> next channel's beat loads on the same edge as the drain.
//  5 Boundary: N_CH=3 build, fixed mode, sel=3 -> no in_ready, out_valid stays 0.
//    RR mode, last grant ch2 -> rr_ptr wraps to 0.
//  6 Mid-op reset: rst=1 while out_valid=1 & out_ready=0 -> out_valid=0 after the edge.
//    RR restarts from ch0 after release.

Source files
------------

// File: rtl/stream_mux.sv
// N-channel registered stream multiplexer with valid/ready handshakes.
// Fixed-select or round-robin arbitration feeds a single-entry output register.
module stream_mux #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_ch
);

  logic [WIDTH-1:0] ch_data [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            can_load;
  logic            rr_found;
  logic [SELW-1:0] rr_grant;
  logic            grant_ok;
  logic [SELW-1:0] grant;
  logic            load;

  always_comb begin
    int unsigned idx;
    idx      = 0;
    can_load = !out_valid_q || out_ready;
    rr_found = 1'b0;
    rr_grant = '0;
    // Scan from rr_ptr upward with wrap; the first requester wins.
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!rr_found && in_valid[idx]) begin
        rr_found = 1'b1;
        rr_grant = SELW'(idx);
      end
    end
    grant    = mode ? rr_grant : sel;
    grant_ok = mode ? rr_found : (int'(sel) < N_CH);
    in_ready = '0;
    if (!rst && can_load && grant_ok) in_ready[grant] = 1'b1;
    load = |(in_valid & in_ready);
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_data_d  = ch_data[grant];
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (mode) rr_ptr_d = (int'(grant) == N_CH - 1) ? '0 : SELW'(grant + 1'b1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: a 4-channel instance checked every cycle
// against a reference model, plus a 3-channel instance for range/wrap cases.
module tb_stream_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode, out_valid, out_ready;
  logic [1:0]  sel, out_ch;
  logic [7:0]  out_data;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic        mode3, out_valid3, out_ready3;
  logic [1:0]  sel3, out_ch3;
  logic [7:0]  out_data3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(8), .N_CH(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  stream_mux #(.WIDTH(8), .N_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_ch(out_ch3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 4-channel instance; one line per accepted beat.
  logic [9:0] sb_q[$];
  bit         m_valid = 1'b0;
  int         m_rr    = 0;

  initial begin
    bit         can, ok, ld;
    int         g;
    logic [3:0] exp_rdy;
    @(posedge clk);
    forever begin
      @(negedge clk);
      can = !m_valid || out_ready;
      ok  = 1'b0;
      g   = 0;
      if (!mode) begin
        if (int'(sel) < 4) begin ok = 1'b1; g = int'(sel); end
      end else begin
        for (int k = 0; k < 4; k++)
          if (!ok && in_valid[(m_rr + k) % 4]) begin ok = 1'b1; g = (m_rr + k) % 4; end
      end
      exp_rdy = (!rst && can && ok) ? 4'(1 << g) : 4'b0000;
      chk("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("sb_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid && sb_q.size() > 0) begin
        chk("sb_out_data", 32'(out_data), 32'(sb_q[0][7:0]));
        chk("sb_out_ch", 32'(out_ch), 32'(sb_q[0][9:8]));
      end
      if (rst) begin
        m_valid = 1'b0;
        m_rr    = 0;
        sb_q.delete();
      end else begin
        ld = can && ok && in_valid[g];
        if (m_valid && out_ready) void'(sb_q.pop_front());
        if (ld) begin
          sb_q.push_back({2'(g), in_data[g*8 +: 8]});
          $display("beat ch=%0d data=%02h mode=%0d", g, in_data[g*8 +: 8], mode);
          m_valid = 1'b1;
          if (mode) m_rr = (g + 1) % 4;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  int rr_a[4]  = '{0, 1, 2, 3};
  int rr_b[4]  = '{0, 2, 0, 2};
  int rr3_a[4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {8'h07, 8'h05, 8'h03, 8'h01};
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {8'h25, 8'h23, 8'h21};

    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    chk("rst_in_ready3", 32'(in_ready3), 32'h0);

    // Fixed select.
    rst = 1'b0; sel = 2'd1;
    step();
    chk("fx1_data", 32'(out_data), 32'h03);
    chk("fx1_ch", 32'(out_ch), 32'h1);
    chk("fx1_valid", 32'(out_valid), 32'h1);
    chk("n3_sel3_in_ready", 32'(in_ready3), 32'h0);
    sel = 2'd0;
    step();
    chk("fx0_data", 32'(out_data), 32'h01);
    chk("fx0_ch", 32'(out_ch), 32'h0);
    chk("n3_sel3_out_valid", 32'(out_valid3), 32'h0);

    // Round-robin, all requesting, then alternate channels.
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_all_ch", 32'(out_ch), 32'(rr_a[i]));
    end
    in_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_0101_ch", 32'(out_ch), 32'(rr_b[i]));
    end

    // Drain, then backpressure with rr_ptr sitting at 3.
    in_valid = 4'h0;
    step();
    chk("drain_valid", 32'(out_valid), 32'h0);
    in_valid = 4'hF; out_ready = 1'b0;
    step();
    chk("bp_ch", 32'(out_ch), 32'h3);
    step(); step();
    chk("bp_hold_valid", 32'(out_valid), 32'h1);
    chk("bp_hold_data", 32'(out_data), 32'h07);
    chk("bp_hold_ch", 32'(out_ch), 32'h3);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    step();
    chk("bp_refill_ch", 32'(out_ch), 32'h0);
    chk("bp_refill_data", 32'(out_data), 32'h01);
    chk("bp_refill_valid", 32'(out_valid), 32'h1);

    // Reset while a beat is held.
    out_ready = 1'b0;
    step();
    chk("mid_held_valid", 32'(out_valid), 32'h1);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    step();
    chk("mid_restart_ch", 32'(out_ch), 32'h0);
    chk("mid_restart_valid", 32'(out_valid), 32'h1);

    // Three-channel round-robin wraps from ch2 back to ch0.
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("n3_rr_ch", 32'(out_ch3), 32'(rr3_a[i]));
      chk("n3_rr_data", 32'(out_data3), 32'(8'h21 + 2 * rr3_a[i]));
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
